pipe_ctrl: RTL

- Central sequencer for the five-stage pipeline registers (IF_ID, ID_EX, EX_MEM, MEM_WB and the PC stage).
- Collects per-stage stall and flush requests and resolves their priority.
- Drives per-stage stall/flush controls and a PC redirect handshake to fetch.
- Keeps saturating performance counters for stall and flush events.

---
 rtl/pipe_pkg.sv | 18 +
 rtl/pipe_ctrl_prio_msb.sv | 22 ++
 rtl/pipe_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared constants and FSM encoding for the pipeline control sequencer.
package pipe_pkg;

    localparam int NSTAGE_DEF = 5;
    localparam int ADDR_W_DEF = 32;

    localparam int STG_IF  = 0;
    localparam int STG_ID  = 1;
    localparam int STG_EX  = 2;
    localparam int STG_MEM = 3;
    localparam int STG_WB  = 4;

    typedef enum logic {
        RUN   = 1'b0,
        REDIR = 1'b1
    } ctrl_state_t;

endpackage

// File: rtl/pipe_ctrl_prio_msb.sv
// Highest-set-bit finder: index of the most significant request plus a valid flag.
module prio_msb #(
    parameter int W  = 5,
    parameter int IW = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]  req_i,
    output logic [IW-1:0] idx_o,
    output logic          vld_o
);

    always_comb begin
        idx_o = '0;
        vld_o = 1'b0;
        for (int k = 0; k < W; k++) begin
            if (req_i[k]) begin
                idx_o = IW'(k);
                vld_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush sequencer with PC redirect handshake and saturating event counters.
// Optional stall watchdog (wdog_timeout output) is built only when PIPE_CTRL_WDOG_EN is defined.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int NSTAGE     = NSTAGE_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int CNT_W      = 32
`ifdef PIPE_CTRL_WDOG_EN
   ,parameter int WDOG_LIMIT = 1024
`endif
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NSTAGE-1:0]        stall_req,
    input  logic [NSTAGE-1:0]        flush_req,
    input  logic [NSTAGE*ADDR_W-1:0] flush_target,
    input  logic                     redir_ready,
    output logic [NSTAGE-1:0]        stall,
    output logic [NSTAGE-1:0]        flush,
    output logic                     redir_valid,
    output logic [ADDR_W-1:0]        redir_pc,
    output logic [CNT_W-1:0]         stall_cnt,
    output logic [CNT_W-1:0]         flush_cnt
`ifdef PIPE_CTRL_WDOG_EN
   ,output logic                     wdog_timeout
`endif
);

    localparam int IW = (NSTAGE > 1) ? $clog2(NSTAGE) : 1;

    ctrl_state_t         state_q;
    logic                redir_valid_q;
    logic [ADDR_W-1:0]   redir_pc_q;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]    flush_cnt_q, flush_cnt_d;

    logic [NSTAGE-1:0]   blocked;
    logic [NSTAGE-1:0]   flush_eff;
    logic [IW-1:0]       s_idx, f_idx;
    logic                s_vld, f_vld;
    logic                stall_evt;
    logic [ADDR_W-1:0]   tgt;
    logic [NSTAGE-1:0]   stall_c, flush_c;

    // A flush source is blocked while it or any older stage is stalled.
    always_comb begin
        logic acc;
        acc     = 1'b0;
        blocked = '0;
        for (int k = NSTAGE - 1; k >= 0; k--) begin
            acc        = acc | stall_req[k];
            blocked[k] = acc;
        end
    end

    assign flush_eff = flush_req & ~blocked;

    prio_msb #(.W(NSTAGE), .IW(IW)) u_stall_prio (
        .req_i (stall_req),
        .idx_o (s_idx),
        .vld_o (s_vld)
    );

    prio_msb #(.W(NSTAGE), .IW(IW)) u_flush_prio (
        .req_i (flush_eff),
        .idx_o (f_idx),
        .vld_o (f_vld)
    );

    assign stall_evt = s_vld & ~f_vld;
    assign tgt       = flush_target[int'(f_idx)*ADDR_W +: ADDR_W];

    always_comb begin
        stall_c = '0;
        flush_c = '0;
        if (f_vld) begin
            for (int k = 0; k < NSTAGE; k++)
                flush_c[k] = (k < int'(f_idx));
        end else if (s_vld) begin
            for (int k = 0; k < NSTAGE; k++) begin
                stall_c[k] = (k <= int'(s_idx));
                flush_c[k] = (k == int'(s_idx) + 1);
            end
        end
        if (state_q == REDIR) begin
            stall_c[STG_IF] = 1'b1;
            flush_c[STG_IF] = 1'b1;
        end
    end

    // Combinational controls are forced quiet while reset is held.
    assign stall = rst ? stall_c : '0;
    assign flush = rst ? flush_c : '0;

    assign stall_cnt_d = (stall_evt && stall_cnt_q != '1) ? stall_cnt_q + 1'b1 : stall_cnt_q;
    assign flush_cnt_d = (f_vld && flush_cnt_q != '1) ? flush_cnt_q + 1'b1 : flush_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= RUN;
            redir_valid_q <= 1'b0;
            redir_pc_q    <= '0;
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            case (state_q)
                RUN: begin
                    if (f_vld) begin
                        redir_pc_q    <= tgt;
                        redir_valid_q <= 1'b1;
                        state_q       <= REDIR;
                    end
                end
                REDIR: begin
                    if (f_vld) begin
                        redir_pc_q    <= tgt;
                        redir_valid_q <= 1'b1;
                    end else if (redir_ready) begin
                        redir_valid_q <= 1'b0;
                        state_q       <= RUN;
                    end
                end
                default: begin
                    redir_valid_q <= 1'b0;
                    state_q       <= RUN;
                end
            endcase
        end
    end

    assign redir_valid = redir_valid_q;
    assign redir_pc    = redir_pc_q;
    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;

`ifdef PIPE_CTRL_WDOG_EN
    localparam int WD_W = $clog2(WDOG_LIMIT + 1);

    logic [WD_W-1:0] wd_cnt_q;
    logic            wdog_q;

    // Consecutive effective-stall counter; the timeout flag is sticky until reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_cnt_q <= '0;
            wdog_q   <= 1'b0;
        end else begin
            if (!stall_evt)
                wd_cnt_q <= '0;
            else if (wd_cnt_q != WD_W'(WDOG_LIMIT))
                wd_cnt_q <= wd_cnt_q + 1'b1;
            if (stall_evt && wd_cnt_q == WD_W'(WDOG_LIMIT - 1))
                wdog_q <= 1'b1;
        end
    end

    assign wdog_timeout = wdog_q;
`endif

endmodule
